// File: rtl/eth_tx_mii_serializer_if.sv
// eth_tx_mii_serializer_if
//
// Byte-stream handshake between the Ethernet transmit FSM and the MII
// serializer. A byte moves on a rising clock edge where s_valid && s_ready.
//
// Signals:
//   s_data   [7:0]  byte from the transmit FSM
//   s_valid         s_data is valid
//   s_last          s_data is the final (last CRC) byte of the frame
//   s_ready         serializer can take the byte this cycle
//
// Modports:
//   master  the transmit FSM side (drives data/valid/last)
//   slave   the serializer side (drives ready)

interface eth_tx_mii_serializer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/eth_tx_mii_serializer.sv
// eth_tx_mii_serializer
//
// Takes the transmit FSM's byte stream and serializes it onto a 4-bit MII
// transmit interface, low nibble first, then holds off the next frame for
// the inter-packet gap. If the upstream stalls mid-frame the frame is
// aborted with one TX_ER cycle and the rest of the frame is discarded.
//
// Parameters:
//   IFG_BYTES  inter-packet gap in byte times (1..255), 2*IFG_BYTES cycles
//
// Ports:
//   clock      MII TX clock, rising edge
//   reset_n    asynchronous active-low reset
//   up         byte-stream handshake (slave modport)
//   mii_txd    MII transmit nibble
//   mii_tx_en  MII transmit enable
//   mii_tx_er  MII transmit error
//   busy       high whenever the serializer is not idle
//   underflow  one-cycle pulse when a frame is aborted by an upstream stall

module eth_tx_mii_serializer #(
    parameter int IFG_BYTES = 12
) (
    input  logic                          clock,
    input  logic                          reset_n,
    eth_tx_mii_serializer_if.slave        up,
    output logic [3:0]                    mii_txd,
    output logic                          mii_tx_en,
    output logic                          mii_tx_er,
    output logic                          busy,
    output logic                          underflow
);

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        ERR,
        DRAIN,
        GAP
    } state_t;

    // 2*255 = 510 is the largest load, so 9 bits never wrap.
    localparam logic [8:0] GAP_LOAD = 9'(2 * IFG_BYTES);

    state_t     state;
    logic [7:0] held;
    logic       held_last;
    logic [8:0] gap_cnt;
    logic       ready;

    // Ready depends only on the current state. In HIGH we can take the next
    // byte straight away unless the byte on the wire is the frame's last one,
    // which keeps back-to-back bytes bubble-free.
    always_comb begin
        ready = 1'b0;
        case (state)
            IDLE:    ready = 1'b1;
            HIGH:    ready = ~held_last;
            DRAIN:   ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    assign up.s_ready = ready;
    assign busy       = (state != IDLE);

    // Single state machine. The MII outputs are flops, and every branch loads
    // the values belonging to the state it is entering, so the outputs line up
    // with the state in the following cycle without any path from the s_*
    // inputs to the pins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            held      <= 8'h00;
            held_last <= 1'b0;
            gap_cnt   <= 9'd0;
            mii_txd   <= 4'h0;
            mii_tx_en <= 1'b0;
            mii_tx_er <= 1'b0;
            underflow <= 1'b0;
        end else begin
            mii_tx_er <= 1'b0;
            underflow <= 1'b0;
            case (state)
                IDLE: begin
                    mii_txd   <= 4'h0;
                    mii_tx_en <= 1'b0;
                    if (up.s_valid) begin
                        held      <= up.s_data;
                        held_last <= up.s_last;
                        mii_txd   <= up.s_data[3:0];
                        mii_tx_en <= 1'b1;
                        state     <= LOW;
                    end
                end
                LOW: begin
                    mii_txd   <= held[7:4];
                    mii_tx_en <= 1'b1;
                    state     <= HIGH;
                end
                HIGH: begin
                    if (held_last) begin
                        mii_txd   <= 4'h0;
                        mii_tx_en <= 1'b0;
                        gap_cnt   <= GAP_LOAD;
                        state     <= GAP;
                    end else if (up.s_valid) begin
                        held      <= up.s_data;
                        held_last <= up.s_last;
                        mii_txd   <= up.s_data[3:0];
                        mii_tx_en <= 1'b1;
                        state     <= LOW;
                    end else begin
                        // Upstream ran dry mid-frame: poison the frame on the wire.
                        mii_txd   <= 4'h0;
                        mii_tx_en <= 1'b1;
                        mii_tx_er <= 1'b1;
                        underflow <= 1'b1;
                        state     <= ERR;
                    end
                end
                ERR: begin
                    mii_txd   <= 4'h0;
                    mii_tx_en <= 1'b0;
                    state     <= DRAIN;
                end
                DRAIN: begin
                    // Swallow the rest of the aborted frame up to its last byte.
                    mii_txd   <= 4'h0;
                    mii_tx_en <= 1'b0;
                    if (up.s_valid && up.s_last) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    mii_txd   <= 4'h0;
                    mii_tx_en <= 1'b0;
                    if (gap_cnt <= 9'd1) begin
                        gap_cnt <= 9'd0;
                        state   <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 9'd1;
                    end
                end
                default: begin
                    mii_txd   <= 4'h0;
                    mii_tx_en <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_mii_serializer.sv
// tb_eth_tx_mii_serializer
//
// Self-checking bench for eth_tx_mii_serializer. Drives frames over the byte
// handshake, records one sample of the DUT per clock on the falling edge and
// compares that trace with the frame-level behaviour expected for each frame
// (nibble order, abort cycle, drain, gap length, busy). A second instance with
// a one-byte gap is exercised with back-to-back single-byte frames.

module tb_eth_tx_mii_serializer;

    localparam int IFG       = 12;
    localparam int IFG_SHORT = 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    eth_tx_mii_serializer_if s_if ();
    eth_tx_mii_serializer_if s1_if ();

    logic [3:0] mii_txd;
    logic       mii_tx_en;
    logic       mii_tx_er;
    logic       busy;
    logic       underflow;

    logic [3:0] mii_txd_s;
    logic       mii_tx_en_s;
    logic       mii_tx_er_s;
    logic       busy_s;
    logic       underflow_s;

    eth_tx_mii_serializer #(.IFG_BYTES(IFG)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .up        (s_if.slave),
        .mii_txd   (mii_txd),
        .mii_tx_en (mii_tx_en),
        .mii_tx_er (mii_tx_er),
        .busy      (busy),
        .underflow (underflow)
    );

    eth_tx_mii_serializer #(.IFG_BYTES(IFG_SHORT)) dut_short (
        .clock     (clock),
        .reset_n   (reset_n),
        .up        (s1_if.slave),
        .mii_txd   (mii_txd_s),
        .mii_tx_en (mii_tx_en_s),
        .mii_tx_er (mii_tx_er_s),
        .busy      (busy_s),
        .underflow (underflow_s)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] txd;
        logic       en;
        logic       er;
        logic       uf;
        logic       rdy;
        logic       bsy;
        logic       acc;
    } sample_t;

    sample_t    trace[$];
    logic [7:0] drvData[$];
    logic       drvLast[$];
    logic       drvStall[$];

    int testsRun    = 0;
    int testsFailed = 0;

    // One trace entry per cycle, taken mid-cycle; acc marks a handshake that
    // completes on the following rising edge.
    always @(negedge clock) begin : monitor
        sample_t smp;
        smp.txd = mii_txd;
        smp.en  = mii_tx_en;
        smp.er  = mii_tx_er;
        smp.uf  = underflow;
        smp.rdy = s_if.s_ready;
        smp.bsy = busy;
        smp.acc = s_if.s_valid & s_if.s_ready;
        trace.push_back(smp);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic clearScenario();
        drvData.delete();
        drvLast.delete();
        drvStall.delete();
        trace.delete();
    endtask

    task automatic addByte(input logic [7:0] d, input logic last, input logic stall);
        drvData.push_back(d);
        drvLast.push_back(last);
        drvStall.push_back(stall);
    endtask

    // A frame of n random bytes; if sent < n the source stalls after byte sent.
    task automatic addRandomFrame(input int n, input int sent);
        for (int i = 0; i < n; i++) begin
            addByte(8'($urandom), 1'(i == n - 1), 1'(sent < n && i == sent - 1));
        end
    endtask

    task automatic sendByte(input logic [7:0] d, input logic last);
        int waited = 0;
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        s_if.s_last  = last;
        @(negedge clock);
        while (s_if.s_ready !== 1'b1 && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        if (s_if.s_ready !== 1'b1) checkOutput("handshake_ready", 32'(s_if.s_ready), 32'd1);
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < drvData.size(); i++) begin
            sendByte(drvData[i], drvLast[i]);
            if (drvStall[i]) begin
                s_if.s_valid = 1'b0;
                repeat (3) @(posedge clock);
                #1;
            end
        end
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge clock);
        while (busy !== 1'b0 && n < 400) begin
            @(negedge clock);
            n++;
        end
        checkOutput("idle_reached", 32'(busy), 32'd0);
        repeat (2) @(negedge clock);
        @(posedge clock);
        #1;
    endtask

    // Expected behaviour of one frame of n bytes starting at drvData[firstByte],
    // of which only the first 'sent' reach the wire before an abort (sent < n).
    task automatic analyzeFrame(input int fromIdx, input int firstByte, input int n,
                                input int sent, output int fallIdx, output int idleIdx);
        int         s;
        int         p;
        int         g;
        int         drained;
        int         quietBad;
        int         busyBad;
        int         ufCount;
        logic [7:0] b;
        logic [3:0] expNib;
        s       = -1;
        fallIdx = 0;
        idleIdx = trace.size();
        for (int i = fromIdx; i < trace.size(); i++) begin
            if (trace[i].en === 1'b1) begin
                s = i;
                break;
            end
        end
        checkOutput("burst_seen", 32'(s >= 0), 32'd1);
        if (s < 0) return;
        checkOutput("accept_before_burst", (s > 0) ? 32'(trace[s-1].acc) : 32'd0, 32'd1);
        if (s + 2 * sent + 2 > trace.size()) begin
            checkOutput("trace_long_enough", 32'(trace.size()), 32'(s + 2 * sent + 2));
            return;
        end
        for (int j = 0; j < 2 * sent; j++) begin
            b      = drvData[firstByte + j / 2];
            expNib = (j % 2 == 1) ? b[7:4] : b[3:0];
            checkOutput($sformatf("nibble%0d", j),
                        32'({trace[s+j].txd, trace[s+j].en, trace[s+j].er}),
                        32'({expNib, 2'b10}));
        end
        p = s + 2 * sent;
        if (sent < n) begin
            checkOutput("abort_cycle", 32'({trace[p].txd, trace[p].en, trace[p].er, trace[p].uf}),
                        32'({4'h0, 3'b111}));
            p++;
            fallIdx  = p;
            drained  = 0;
            quietBad = 0;
            while (p < trace.size() && trace[p].rdy === 1'b1) begin
                if (trace[p].en !== 1'b0 || trace[p].er !== 1'b0) quietBad++;
                drained += int'(trace[p].acc);
                p++;
            end
            checkOutput("drained_bytes", 32'(drained), 32'(n - sent));
            checkOutput("drain_quiet", 32'(quietBad), 32'd0);
        end else begin
            fallIdx = p;
        end
        g        = 0;
        quietBad = 0;
        while (p < trace.size() && trace[p].rdy === 1'b0 && g < 600) begin
            if (trace[p].en !== 1'b0 || trace[p].er !== 1'b0) quietBad++;
            g++;
            p++;
        end
        checkOutput("gap_cycles", 32'(g), 32'(2 * IFG));
        checkOutput("gap_quiet", 32'(quietBad), 32'd0);
        if (p < trace.size())
            checkOutput("idle_after_gap", 32'({trace[p].rdy, trace[p].bsy, trace[p].en}), 32'(3'b100));
        else
            checkOutput("idle_after_gap_seen", 32'(p), 32'(trace.size() - 1));
        busyBad = 0;
        ufCount = 0;
        for (int i = s; i < p && i < trace.size(); i++) begin
            if (trace[i].bsy !== 1'b1) busyBad++;
            ufCount += int'(trace[i].uf);
        end
        checkOutput("busy_in_frame", 32'(busyBad), 32'd0);
        checkOutput("underflow_pulses", 32'(ufCount), (sent < n) ? 32'd1 : 32'd0);
        idleIdx = p;
    endtask

    task automatic checkResetOutputs(input string where);
        checkOutput({where, "_txd"},       32'(mii_txd),      32'd0);
        checkOutput({where, "_tx_en"},     32'(mii_tx_en),    32'd0);
        checkOutput({where, "_tx_er"},     32'(mii_tx_er),    32'd0);
        checkOutput({where, "_underflow"}, 32'(underflow),    32'd0);
        checkOutput({where, "_busy"},      32'(busy),         32'd0);
        checkOutput({where, "_s_ready"},   32'(s_if.s_ready), 32'd1);
    endtask

    task automatic releaseReset();
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    int         fall;
    int         idle;
    int         accIdx;
    int         n;
    int         sent;
    logic [7:0] d;

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        s_if.s_valid  = 1'b0;
        s_if.s_data   = 8'h00;
        s_if.s_last   = 1'b0;
        s1_if.s_valid = 1'b0;
        s1_if.s_data  = 8'h00;
        s1_if.s_last  = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Reset asserted mid-cycle while random traffic is flowing.
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(5, 40)) begin
                @(posedge clock);
                #1;
                s_if.s_valid = 1'($urandom);
                s_if.s_data  = 8'($urandom);
                s_if.s_last  = 1'($urandom_range(0, 3) == 0);
            end
            @(posedge clock);
            #3 reset_n = 1'b0;
            #1 checkResetOutputs("reset");
            releaseReset();
        end

        // Directed 3-byte frame.
        clearScenario();
        addByte(8'h55, 1'b0, 1'b0);
        addByte(8'hD5, 1'b0, 1'b0);
        addByte(8'hA3, 1'b1, 1'b0);
        applyStimulus();
        waitIdle();
        analyzeFrame(0, 0, 3, 3, fall, idle);

        // Two 4-byte frames with s_valid held throughout.
        clearScenario();
        addRandomFrame(4, 4);
        addRandomFrame(4, 4);
        applyStimulus();
        waitIdle();
        analyzeFrame(0, 0, 4, 4, fall, idle);
        accIdx = -1;
        for (int i = fall; i < trace.size(); i++) begin
            if (trace[i].acc === 1'b1) begin
                accIdx = i;
                break;
            end
        end
        checkOutput("b2b_accept_delay", 32'(accIdx - fall + 1), 32'(2 * IFG + 1));
        analyzeFrame(idle, 4, 4, 4, fall, idle);

        // Underflow after two bytes.
        clearScenario();
        addByte(8'h12, 1'b0, 1'b0);
        addByte(8'h34, 1'b0, 1'b1);
        addByte(8'($urandom), 1'b0, 1'b0);
        addByte(8'($urandom), 1'b1, 1'b0);
        applyStimulus();
        waitIdle();
        analyzeFrame(0, 0, 4, 2, fall, idle);

        // Single-byte frame.
        clearScenario();
        addByte(8'h0F, 1'b1, 1'b0);
        applyStimulus();
        waitIdle();
        analyzeFrame(0, 0, 1, 1, fall, idle);

        // Random frames, some aborted by a stall.
        for (int f = 0; f < 20; f++) begin
            n    = $urandom_range(1, 8);
            sent = n;
            if (n >= 2 && $urandom_range(0, 2) == 0) sent = $urandom_range(1, n - 1);
            clearScenario();
            addRandomFrame(n, sent);
            applyStimulus();
            waitIdle();
            analyzeFrame(0, 0, n, sent, fall, idle);
        end

        // One-byte gap: single-byte frames repeat every 5 cycles (1,1,0,0,idle).
        s1_if.s_valid = 1'b1;
        s1_if.s_last  = 1'b1;
        for (int f = 0; f < 4; f++) begin
            d = 8'($urandom);
            s1_if.s_data = d;
            @(negedge clock);
            checkOutput("short_idle", 32'({s1_if.s_ready, mii_tx_en_s}), 32'(2'b10));
            @(negedge clock);
            checkOutput("short_low", 32'({mii_tx_en_s, mii_txd_s}), 32'({1'b1, d[3:0]}));
            @(negedge clock);
            checkOutput("short_high", 32'({mii_tx_en_s, mii_txd_s}), 32'({1'b1, d[7:4]}));
            @(negedge clock);
            checkOutput("short_gap0", 32'({mii_tx_en_s, s1_if.s_ready}), 32'(2'b00));
            @(negedge clock);
            checkOutput("short_gap1", 32'({mii_tx_en_s, s1_if.s_ready}), 32'(2'b00));
        end
        s1_if.s_valid = 1'b0;
        s1_if.s_last  = 1'b0;
        @(posedge clock);
        #1;

        // Reset during the high nibble of byte 5, then a normal frame.
        clearScenario();
        addRandomFrame(8, 8);
        for (int i = 0; i < 5; i++) sendByte(drvData[i], drvLast[i]);
        s_if.s_data = drvData[5];
        @(posedge clock);
        #2;
        checkOutput("pre_reset_high_nibble", 32'({mii_tx_en, mii_txd}), 32'({1'b1, drvData[4][7:4]}));
        #1 reset_n = 1'b0;
        #1 checkResetOutputs("reset_in_frame");
        releaseReset();
        clearScenario();
        addRandomFrame(5, 5);
        applyStimulus();
        waitIdle();
        analyzeFrame(0, 0, 5, 5, fall, idle);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
